// File: rtl/spi_ss_sequencer.sv
// rtl/spi_ss_sequencer.sv - queued SPI frame sequencer with one-hot active-low slave selects
//
// Purpose: accepts {ss_sel, cmd} requests into a small FIFO and plays each one
// out as a full SPI frame (SCLK idle high, MOSI changes on falling edges,
// MISO captured on rising edges), framed by a select-setup and select-hold
// half period plus an inter-frame gap.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wrt/ss_sel/cmd  single-cycle enqueue request (target slave, frame to send)
//   full, busy      queue full / queue non-empty or frame in progress
//   done            one-cycle pulse when a frame completes
//   rd_data, rd_ss  MISO bits and target of the last completed frame
//   err             one-cycle pulse when a request is dropped
//   MISO, MOSI      serial data in / out
//   SCLK            SPI clock, idle high
//   ss_n            active-low one-hot slave selects
module spi_ss_sequencer #(
  parameter int NUM_SS     = 5,
  parameter int FRAME_W    = 16,
  parameter int SCLK_DIV   = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int SS_W      = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wrt,
  input  logic [SS_W-1:0]    ss_sel,
  input  logic [FRAME_W-1:0] cmd,
  output logic               full,
  output logic               busy,
  output logic               done,
  output logic [FRAME_W-1:0] rd_data,
  output logic [SS_W-1:0]    rd_ss,
  output logic               err,
  input  logic               MISO,
  output logic               MOSI,
  output logic               SCLK,
  output logic [NUM_SS-1:0]  ss_n
);

  localparam int HALF  = SCLK_DIV / 2;
  localparam int HC_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int NH    = 2 * FRAME_W;
  localparam int NH_W  = $clog2(NH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, FRONT, SHIFT, BACK, GAP} state_t;

  state_t             state, state_nxt;
  logic [HC_W-1:0]    hcnt;
  logic [NH_W-1:0]    half_idx;
  logic               half_end;
  logic [FRAME_W-1:0] tx_sr, rx_sr;
  logic [SS_W-1:0]    cur_ss;

  logic [SS_W-1:0]    q_ss  [FIFO_DEPTH];
  logic [FRAME_W-1:0] q_cmd [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [PTR_W:0]     count;
  logic               pop, push, sel_ok;

  // ---------------- command queue ----------------
  assign sel_ok = ({1'b0, ss_sel} < (SS_W+1)'(NUM_SS));
  assign full   = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign pop    = (state == IDLE) && (count != '0);
  // A full queue still takes a request in the cycle the head is popped.
  assign push   = wrt && sel_ok && (!full || pop);
  assign busy   = (count != '0) || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      q_ss[wr_ptr]  <= ss_sel;
      q_cmd[wr_ptr] <= cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      err <= wrt && !push;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  assign half_end = (hcnt == HC_W'(HALF - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0) state_nxt = FRONT;
      FRONT:   if (half_end) state_nxt = SHIFT;
      SHIFT:   if (half_end && half_idx == NH_W'(NH - 1)) state_nxt = BACK;
      BACK:    if (half_end) state_nxt = GAP;
      GAP:     if (half_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  // Every non-idle state is built from half-SCLK-period slices; hcnt times a
  // slice and half_idx numbers the slices inside SHIFT (even = SCLK low).
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt     <= '0;
      half_idx <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      cur_ss   <= '0;
      done     <= 1'b0;
      rd_data  <= '0;
      rd_ss    <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE || half_end) hcnt <= '0;
      else                           hcnt <= hcnt + HC_W'(1);
      case (state)
        IDLE: if (pop) begin
          tx_sr    <= q_cmd[rd_ptr];
          cur_ss   <= q_ss[rd_ptr];
          rx_sr    <= '0;
          half_idx <= '0;
        end
        SHIFT: if (half_end) begin
          half_idx <= half_idx + NH_W'(1);
          if (!half_idx[0])
            rx_sr <= {rx_sr[FRAME_W-2:0], MISO};       // SCLK rising
          else if (half_idx != NH_W'(NH - 1))
            tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};       // SCLK falling, not the first
        end
        BACK: if (half_end) begin
          done    <= 1'b1;
          rd_data <= rx_sr;
          rd_ss   <= cur_ss;
        end
        default: ;
      endcase
    end
  end

  // MOSI only moves when tx_sr shifts, so it is stable outside falling edges.
  assign MOSI = tx_sr[FRAME_W-1];

  // ---------------- FSM: outputs ----------------
  always_comb begin
    SCLK = 1'b1;
    ss_n = '1;
    case (state)
      FRONT, BACK: ss_n = ~(NUM_SS'(1) << cur_ss);
      SHIFT: begin
        ss_n = ~(NUM_SS'(1) << cur_ss);
        SCLK = half_idx[0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_ss_sequencer.sv
// tb/tb_spi_ss_sequencer.sv - scoreboard bench for spi_ss_sequencer
module tb_spi_ss_sequencer;
  localparam int NUM_SS = 5, FRAME_W = 16, SCLK_DIV = 16, FIFO_DEPTH = 4;
  localparam int LOW    = (FRAME_W + 1) * SCLK_DIV;   // ss_n low cycles per frame
  localparam int PERIOD = LOW + SCLK_DIV / 2 + 1;     // pop-to-next-pop spacing

  logic clk = 0, rst = 1, wrt = 0, miso_inv = 0;
  logic [2:0] ss_sel = 0;
  logic [15:0] cmd = 0;
  logic full, busy, done, err, MISO, MOSI, SCLK;
  logic [15:0] rd_data;
  logic [2:0] rd_ss;
  logic [4:0] ss_n;

  logic s_wrt = 0;
  logic [1:0] s_sel = 0;
  logic [7:0] s_cmd = 0;
  logic s_full, s_busy, s_done, s_err, s_mosi, s_sclk;
  logic [7:0] s_rd_data;
  logic [1:0] s_rd_ss;
  logic [2:0] s_ss_n;

  assign MISO = MOSI ^ miso_inv;

  spi_ss_sequencer dut (
    .clk(clk), .rst(rst), .wrt(wrt), .ss_sel(ss_sel), .cmd(cmd), .full(full),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_ss(rd_ss), .err(err),
    .MISO(MISO), .MOSI(MOSI), .SCLK(SCLK), .ss_n(ss_n));

  spi_ss_sequencer #(.NUM_SS(3), .FRAME_W(8), .SCLK_DIV(4), .FIFO_DEPTH(4)) dut_s (
    .clk(clk), .rst(rst), .wrt(s_wrt), .ss_sel(s_sel), .cmd(s_cmd), .full(s_full),
    .busy(s_busy), .done(s_done), .rd_data(s_rd_data), .rd_ss(s_rd_ss), .err(s_err),
    .MISO(1'b1), .MOSI(s_mosi), .SCLK(s_sclk), .ss_n(s_ss_n));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Queue of pending requests plus the cycle at which the engine is next free.
  typedef struct packed { logic [2:0] ss; logic [15:0] cmd; } ent_t;
  typedef struct packed { logic [2:0] ss; logic [15:0] cmd; logic [15:0] rd; } fr_t;
  ent_t mq[$];
  fr_t  sb[$];
  int   m_free = 0, m_pop = -100000;
  logic [2:0] m_ss = 0;
  logic m_err = 0, m_on = 0, m_popn, m_acc;
  logic [4:0] exp_ssn;
  ent_t m_e;

  always @(negedge clk) begin
    if (m_on) begin
      exp_ssn = (cyc > m_pop && cyc <= m_pop + LOW) ? ~(5'b00001 << m_ss) : 5'b11111;
      chk("busy", busy, (mq.size() > 0) || (cyc < m_free));
      chk("full", full, mq.size() == FIFO_DEPTH);
      chk("err", err, m_err);
      chk("done", done, cyc == m_pop + LOW + 1);
      chk("ss_n", ss_n, exp_ssn);
    end
    if (rst) begin
      mq.delete(); sb.delete();
      m_free = cyc + 1; m_pop = -100000; m_err = 0; m_on = 1;
    end else if (m_on) begin
      m_popn = (mq.size() > 0) && (cyc >= m_free);
      m_acc  = wrt && (ss_sel < NUM_SS) && ((mq.size() < FIFO_DEPTH) || m_popn);
      m_err  = wrt && !m_acc;
      if (m_popn) begin
        m_e = mq.pop_front();
        m_pop = cyc; m_ss = m_e.ss; m_free = cyc + PERIOD;
        sb.push_back({m_e.ss, m_e.cmd, m_e.cmd ^ {16{miso_inv}}});
      end
      if (m_acc) mq.push_back({ss_sel, cmd});
    end
  end

  // ---------------- monitor ----------------
  logic prev_sclk = 1, prev_act = 0, act;
  int falls = 0, rises = 0;
  logic [15:0] mosi_bits = 0;
  fr_t f;

  always @(negedge clk) begin
    act = (ss_n !== 5'b11111) && !rst;
    if (act && !prev_act) begin falls = 0; rises = 0; mosi_bits = 0; end
    if (act) begin
      if (prev_sclk && !SCLK) falls++;
      if (!prev_sclk && SCLK) begin mosi_bits = {mosi_bits[14:0], MOSI}; rises++; end
    end
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL done: pulse with no frame expected (cycle %0d)", cyc);
      end else begin
        f = sb.pop_front();
        chk("rd_ss", rd_ss, f.ss);
        chk("rd_data", rd_data, f.rd);
        chk("mosi_bits", mosi_bits, f.cmd);
        chk("sclk_falls", falls, FRAME_W);
        chk("sclk_rises", rises, FRAME_W);
      end
    end
    prev_sclk = SCLK;
    prev_act  = act;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] s, input logic [15:0] c);
    ss_sel = s; cmd = c; wrt = 1;
    tick();
    wrt = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin tick(); n++; end
    if (n >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
    tick(); tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, low, dn;
    repeat (3) tick();
    rst = 0;
    @(negedge clk);
    chk("rst_sclk", SCLK, 1);
    chk("rst_mosi", MOSI, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_ss", rd_ss, 0);
    tick();

    // single loopback frame
    wr(3'd2, 16'hA5C3);
    wait_idle();

    // out-of-range targets are dropped
    wr(3'd6, 16'h1234); wr(3'd5, 16'h0F0F); wr(3'd7, 16'hFFFF);
    repeat (5) tick();
    wait_idle();

    // five back-to-back requests behind a running frame: fifth overflows
    wr(3'd4, 16'h6E21);
    repeat (20) tick();
    for (int i = 0; i < 5; i++) wr(i[2:0], 16'($urandom));
    wait_idle();

    // full queue with a write landing in the pop cycle
    miso_inv = 1;
    wr(3'd1, 16'h8001);
    repeat (10) tick();
    for (int i = 0; i < 4; i++) wr(i[2:0], 16'($urandom));
    n = 0;
    while (cyc < m_free && n < 400) begin tick(); n++; end
    wr(3'd3, 16'hBEEF);
    @(negedge clk);
    chk("full_pop_err", err, 0);
    chk("full_pop_full", full, 1);
    tick();
    wait_idle();

    // reset in the middle of a frame with one more request queued
    miso_inv = 0;
    wr(3'd3, 16'hC0DE); wr(3'd0, 16'h5A5A);
    n = 0;
    while (ss_n === 5'b11111 && n < 50) begin tick(); n++; end
    repeat (100) tick();
    rst = 1; tick(); rst = 0;
    @(negedge clk);
    chk("abort_ss_n", ss_n, 5'b11111);
    chk("abort_busy", busy, 0);
    chk("abort_rd_data", rd_data, 0);
    tick();
    repeat (400) tick();

    // randomized traffic with occasional bursts
    miso_inv = 1'($urandom);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        n = $urandom_range(1, 6);
        for (int k = 0; k < n; k++) wr(3'($urandom_range(0, 7)), 16'($urandom));
      end else tick();
    end
    wait_idle();

    // reduced-size instance, MISO tied high
    s_sel = 2'd1; s_cmd = 8'h3C; s_wrt = 1;
    tick();
    s_wrt = 0;
    low = 0; dn = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_ss_n !== 3'b111) begin
        low++;
        chk("small_ss_n", s_ss_n, 3'b101);
      end
      if (s_done === 1'b1) begin
        dn++;
        chk("small_rd_data", s_rd_data, 8'hFF);
        chk("small_rd_ss", s_rd_ss, 2'd1);
      end
    end
    chk("small_low_time", low, 36);
    chk("small_done_count", dn, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
